sts_preamble_gen: RTL and testbench

//  Transmit-side short training sequence (STS) generator: emits the 802.11a short preamble,
//  N_REPS repetitions of the 16-sample periodic STS, as strobed I/Q samples.

---
 rtl/sts_preamble_gen.sv | 172 +++++++++++++++++
 tb/tb_sts_preamble_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sts_preamble_gen.sv
`default_nettype none
// ============================================================================
// Module      : sts_preamble_gen
// Description : 802.11a short-training-sequence generator. It emits N_REPS
//               repetitions of the 16-sample STS as strobed I/Q samples.
//               Optional macro STS_WINDOW_EN halves the first sample and adds
//               a half-amplitude trailing ROM[0] sample.
// Revision    : 1.0 - initial release
// ============================================================================
module sts_preamble_gen #(
  parameter int DATA_W = 16,
  parameter int N_REPS = 10,
  parameter int REP_W  = 4
) (
  input  logic                     CLK,
  input  logic                     s_RST,
  input  logic                     In_Start,
  input  logic                     In_Sample_Tick,
  input  logic                     enable,
  output logic                     Out_Strobe,
  output logic signed [DATA_W-1:0] Out_I,
  output logic signed [DATA_W-1:0] Out_Q,
  output logic                     Out_Sym_Last,
  output logic                     Out_Busy,
  output logic                     Out_Done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One STS period, time-domain, scaled by 8192 and rounded to nearest
  localparam logic signed [15:0] c_STS_I [16] = '{
    16'sd377,   -16'sd1085, -16'sd111,  16'sd1170,
    16'sd754,   16'sd1170,  -16'sd111,  -16'sd1085,
    16'sd377,   16'sd19,    -16'sd643,  -16'sd104,
    16'sd0,     -16'sd104,  -16'sd643,  16'sd19
  };
  localparam logic signed [15:0] c_STS_Q [16] = '{
    16'sd377,   16'sd19,    -16'sd643,  -16'sd104,
    16'sd0,     -16'sd104,  -16'sd643,  16'sd19,
    16'sd377,   -16'sd1085, -16'sd111,  16'sd1170,
    16'sd754,   16'sd1170,  -16'sd111,  -16'sd1085
  };

  localparam logic [REP_W-1:0] c_LAST_REP = REP_W'(N_REPS - 1);
`ifdef STS_WINDOW_EN
  localparam state_t c_AFTER_LAST = ST_TAIL;
`else
  localparam state_t c_AFTER_LAST = ST_DONE;
`endif

  state_t                    r_state, w_state_nxt;
  logic [3:0]                r_idx, w_idx_nxt;
  logic [REP_W-1:0]          r_rep, w_rep_nxt;
  logic                      r_strobe, w_strobe_nxt;
  logic                      r_last, w_last_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_done, w_done_nxt;
  logic signed [DATA_W-1:0]  r_i, w_i_nxt;
  logic signed [DATA_W-1:0]  r_q, w_q_nxt;
  logic signed [DATA_W-1:0]  w_rom_i, w_rom_q;
  logic signed [DATA_W-1:0]  w_smp_i, w_smp_q;
  logic                      w_half;

  always_comb begin
    w_rom_i = DATA_W'(c_STS_I[r_idx]);
    w_rom_q = DATA_W'(c_STS_Q[r_idx]);
`ifdef STS_WINDOW_EN
    // Edge samples: the very first one and the trailing ROM[0] (idx already wrapped to 0)
    w_half = (r_state == ST_TAIL) || ((r_rep == '0) && (r_idx == 4'd0));
`else
    w_half = 1'b0;
`endif
    w_smp_i = w_half ? (w_rom_i >>> 1) : w_rom_i;
    w_smp_q = w_half ? (w_rom_q >>> 1) : w_rom_q;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_rep_nxt    = r_rep;
    w_strobe_nxt = 1'b0;
    w_last_nxt   = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_i_nxt      = r_i;
    w_q_nxt      = r_q;

    case (r_state)
      ST_IDLE: begin
        if (In_Start) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = 4'd0;
          w_rep_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (In_Sample_Tick) begin
          w_strobe_nxt = 1'b1;
          w_i_nxt      = w_smp_i;
          w_q_nxt      = w_smp_q;
          w_last_nxt   = (r_idx == 4'd15);
          w_idx_nxt    = r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            if (r_rep == c_LAST_REP) begin
              w_state_nxt = c_AFTER_LAST;
              w_rep_nxt   = '0;
            end else begin
              w_rep_nxt = r_rep + 1'b1;
            end
          end
        end
      end
      ST_TAIL: begin
        if (In_Sample_Tick) begin
          w_strobe_nxt = 1'b1;
          w_i_nxt      = w_smp_i;
          w_q_nxt      = w_smp_q;
          w_state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Disable behaves exactly like reset: everything returns to zero next cycle
  always_ff @(posedge CLK) begin
    if (!s_RST || !enable) begin
      r_state  <= ST_IDLE;
      r_idx    <= 4'd0;
      r_rep    <= '0;
      r_strobe <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_i      <= '0;
      r_q      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_rep    <= w_rep_nxt;
      r_strobe <= w_strobe_nxt;
      r_last   <= w_last_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_i      <= w_i_nxt;
      r_q      <= w_q_nxt;
    end
  end

  assign Out_Strobe   = r_strobe;
  assign Out_I        = r_i;
  assign Out_Q        = r_q;
  assign Out_Sym_Last = r_last;
  assign Out_Busy     = r_busy;
  assign Out_Done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sts_preamble_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sts_preamble_gen
// Description : Scoreboard bench for sts_preamble_gen (honours STS_WINDOW_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sts_preamble_gen;

`ifdef STS_WINDOW_EN
  localparam int c_N_REPS = 2;
  localparam bit c_WIN    = 1'b1;
`else
  localparam int c_N_REPS = 10;
  localparam bit c_WIN    = 1'b0;
`endif
  localparam int c_TOTAL = 16 * c_N_REPS + (c_WIN ? 1 : 0);

  localparam int c_ROM_I [16] = '{377, -1085, -111, 1170, 754, 1170, -111, -1085,
                                  377, 19, -643, -104, 0, -104, -643, 19};
  localparam int c_ROM_Q [16] = '{377, 19, -643, -104, 0, -104, -643, 19,
                                  377, -1085, -111, 1170, 754, 1170, -111, -1085};

  typedef struct {
    int   i;
    int   q;
    logic last;
    logic fin;
  } exp_t;

  logic CLK = 1'b0;
  logic s_RST = 1'b0, In_Start = 1'b0, In_Sample_Tick = 1'b0, enable = 1'b0;
  logic Out_Strobe, Out_Sym_Last, Out_Busy, Out_Done;
  logic signed [15:0] Out_I, Out_Q;

  always #5 CLK = ~CLK;

  sts_preamble_gen #(.DATA_W(16), .N_REPS(c_N_REPS), .REP_W(4)) u_dut (
    .CLK(CLK), .s_RST(s_RST), .In_Start(In_Start), .In_Sample_Tick(In_Sample_Tick),
    .enable(enable), .Out_Strobe(Out_Strobe), .Out_I(Out_I), .Out_Q(Out_Q),
    .Out_Sym_Last(Out_Sym_Last), .Out_Busy(Out_Busy), .Out_Done(Out_Done)
  );

  int   n_checks = 0, n_errors = 0;
  int   n_seen = 0, n_last = 0, n_done = 0, m_pushed = 0;
  exp_t sb[$];
  logic exp_tick = 1'b0, r_pend = 1'b0, r_exp_done = 1'b0;
  bit   m_active = 0, m_done = 0, m_tail = 0;
  int   m_idx = 0, m_rep = 0;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int half(input int v);
    return (v < 0) ? (v - 1) / 2 : v / 2;
  endfunction

  // One clock of stimulus; the reference model decides whether the tick is consumed
  task automatic step(input logic tick, input logic start, input logic en, input logic rst_n);
    exp_t e;
    logic acc;
    acc = 1'b0;
    if (!rst_n || !en) begin
      m_active = 0; m_done = 0; m_tail = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (tick) begin
        acc = 1'b1;
        if (m_tail) begin
          e.i = half(c_ROM_I[0]); e.q = half(c_ROM_Q[0]); e.last = 1'b0; e.fin = 1'b1;
          m_tail = 0; m_active = 0; m_done = 1;
        end else begin
          e.i = c_ROM_I[m_idx]; e.q = c_ROM_Q[m_idx];
          if (c_WIN && m_rep == 0 && m_idx == 0) begin
            e.i = half(e.i); e.q = half(e.q);
          end
          e.last = (m_idx == 15);
          e.fin  = 1'b0;
          if (m_idx == 15) begin
            m_idx = 0;
            if (m_rep == c_N_REPS - 1) begin
              if (c_WIN) m_tail = 1;
              else begin
                e.fin = 1'b1; m_active = 0; m_done = 1;
              end
            end else m_rep++;
          end else m_idx++;
        end
        sb.push_back(e);
        m_pushed++;
      end
    end else if (start) begin
      m_active = 1; m_idx = 0; m_rep = 0; m_tail = 0;
    end
    In_Sample_Tick = tick; In_Start = start; enable = en; s_RST = rst_n; exp_tick = acc;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_strobe"}, Out_Strobe, 0);
    check({tag, "_i"}, Out_I, 0);
    check({tag, "_q"}, Out_Q, 0);
    check({tag, "_last"}, Out_Sym_Last, 0);
    check({tag, "_busy"}, Out_Busy, 0);
    check({tag, "_done"}, Out_Done, 0);
  endtask

  // Full preamble with optional mid-run restart attempt or abort (enable or reset)
  task automatic run_seq(input int period, input int restart_at, input int abort_at,
                         input bit abort_rst);
    int  base, seen0, last0, done0, cyc, k;
    bit  aborted;
    logic t;
    base = m_pushed; seen0 = n_seen; last0 = n_last; done0 = n_done;
    aborted = 0; cyc = 1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    while ((m_active || m_done) && !aborted && cyc < 5000) begin
      t = ((cyc % period) == 0);
      k = m_pushed - base;
      if (abort_at >= 0 && k == abort_at && m_active) begin
        if (abort_rst) step(1'b0, 1'b0, 1'b1, 1'b0);
        else step(1'b0, 1'b0, 1'b0, 1'b1);
        check_cleared(abort_rst ? "rst_abort" : "en_abort");
        aborted = 1;
      end else begin
        step(t, (restart_at >= 0 && k == restart_at), 1'b1, 1'b1);
      end
      cyc++;
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    if (aborted) begin
      check("abort_no_done", n_done - done0, 0);
      for (int j = 0; j < 20; j++) step(1'b1, 1'b0, 1'b1, 1'b1);
      check("no_strobe_wo_start", n_seen - seen0, abort_at);
    end else begin
      check("seq_finished", {31'd0, (m_active || m_done)}, 0);
      check("n_strobes", n_seen - seen0, c_TOTAL);
      check("n_sym_last", n_last - last0, c_N_REPS);
      check("n_done", n_done - done0, 1);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    logic exp_done_now;
    exp_done_now = r_exp_done;
    r_exp_done = 1'b0;
    if (Out_Strobe === 1'b1 || r_pend) check("strobe", Out_Strobe, r_pend);
    if (Out_Strobe === 1'b1) begin
      n_seen++;
      if (Out_Sym_Last) n_last++;
      check("sb_avail", {31'd0, (sb.size() > 0)}, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_i", Out_I, e.i);
        check("out_q", Out_Q, e.q);
        check("sym_last", Out_Sym_Last, e.last);
        check("busy_at_strobe", Out_Busy, 1);
        r_exp_done = e.fin;
      end
    end
    if (Out_Done === 1'b1 || exp_done_now) begin
      check("done", Out_Done, exp_done_now);
      check("busy_at_done", Out_Busy, 0);
      if (Out_Done === 1'b1) n_done++;
    end
    r_pend = exp_tick;
  end

  initial begin
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_cleared("reset");
    for (int j = 0; j < 5; j++) step(1'b1, 1'b0, 1'b1, 1'b1);
    check("idle_ticks", n_seen, 0);

    run_seq(4, -1, -1, 1'b0);
    run_seq(1, -1, -1, 1'b0);
    run_seq(1, 50, -1, 1'b0);
    run_seq(2, -1, 70, 1'b0);
    run_seq(1, -1, -1, 1'b0);
    run_seq(3, -1, 100, 1'b1);
    run_seq(1, -1, -1, 1'b0);

    check("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
